// File: rtl/imm_value_buffer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imm_value_buffer_pkg
//  Description : Shared default sizing for the immediate/PC value buffer.
//                The same defaults are used by the rename and reservation-
//                station logic, so they are collected here in one place.
//  Revision    : 1.0  initial release
// ============================================================================
package imm_value_buffer_pkg;

    // Number of buffer entries and the pointer width needed to address them
    localparam int unsigned c_buffer_num   = 32;
    localparam int unsigned c_buffer_sel   = 5;

    // Width of one stored immediate or PC value
    localparam int unsigned c_data_depth   = 32;

    // One-hot speculative branch tag width
    localparam int unsigned c_spec_tag_len = 5;

    // Dispatch write channels and issue read channels
    localparam int unsigned c_disp_width   = 2;
    localparam int unsigned c_issue_width  = 2;

endpackage : imm_value_buffer_pkg
`default_nettype wire

// File: rtl/imm_value_buffer_free_entry_select.sv
`default_nettype none
// ============================================================================
//  Module      : imm_value_buffer_free_entry_select
//  Description : Multi-output priority encoder (free_entry_select). Returns
//                the PICK_NUM lowest set indices of a free-entry vector,
//                lowest first, with a found flag per output.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_value_buffer_free_entry_select #(
    parameter int ENTRY_NUM = 32,
    parameter int SEL_WIDTH = 5,
    parameter int PICK_NUM  = 2
) (
    input  logic [ENTRY_NUM-1:0]          free_vec,
    output logic [PICK_NUM*SEL_WIDTH-1:0] pick_ptr,
    output logic [PICK_NUM-1:0]           pick_found
);

    logic [ENTRY_NUM-1:0] w_remaining;
    logic                 w_hit;

    // Peel off the lowest free index once per output; each chosen entry is
    // removed from the working vector so the next output sees the next one.
    always_comb begin
        w_remaining = free_vec;
        pick_ptr    = '0;
        pick_found  = '0;
        w_hit       = 1'b0;
        for (int k = 0; k < PICK_NUM; k++) begin
            w_hit = 1'b0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                if (w_remaining[i] && !w_hit) begin
                    w_hit                               = 1'b1;
                    w_remaining[i]                      = 1'b0;
                    pick_ptr[k*SEL_WIDTH +: SEL_WIDTH]  = SEL_WIDTH'(i);
                end
            end
            pick_found[k] = w_hit;
        end
    end

endmodule : imm_value_buffer_free_entry_select
`default_nettype wire

// File: rtl/imm_value_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : imm_value_buffer
//  Description : Dispatch-side immediate/PC value store. Owns its free list,
//                offers DISP_WIDTH entry pointers per cycle, stores one value
//                and one branch-dependency mask per entry, returns values to
//                ISSUE_WIDTH ports one cycle after the read, and frees only
//                the entries that depend on a mispredicted branch.
//  Revision    : 1.0  initial release
// ============================================================================
module imm_value_buffer
    import imm_value_buffer_pkg::*;
#(
    parameter int BUFFER_NUM   = c_buffer_num,
    parameter int BUFFER_SEL   = c_buffer_sel,
    parameter int DATA_DEPTH   = c_data_depth,
    parameter int DISP_WIDTH   = c_disp_width,
    parameter int ISSUE_WIDTH  = c_issue_width,
    parameter int SPEC_TAG_LEN = c_spec_tag_len
) (
    input  logic                              clk,
    input  logic                              reset,
    output logic [DISP_WIDTH*BUFFER_SEL-1:0]  alloc_ptr,
    output logic                              alloc_ready,
    output logic [BUFFER_SEL:0]               free_count,
    input  logic [DISP_WIDTH-1:0]             disp_valid,
    input  logic [DISP_WIDTH*DATA_DEPTH-1:0]  disp_value,
    input  logic [DISP_WIDTH*SPEC_TAG_LEN-1:0] disp_spectag,
    input  logic [ISSUE_WIDTH-1:0]            issue_valid,
    input  logic [ISSUE_WIDTH*BUFFER_SEL-1:0] issue_ptr,
    output logic [ISSUE_WIDTH*DATA_DEPTH-1:0] issue_value,
    input  logic                              prmiss,
    input  logic                              prsuccess,
    input  logic [SPEC_TAG_LEN-1:0]           prtag
);

    // ------------------------------------------------------------------
    // Entry state
    // ------------------------------------------------------------------
    logic [BUFFER_NUM-1:0]   r_valid;
    logic [DATA_DEPTH-1:0]   r_value [BUFFER_NUM];
    logic [SPEC_TAG_LEN-1:0] r_mask  [BUFFER_NUM];
    logic [BUFFER_SEL:0]     r_free_count;
    logic [ISSUE_WIDTH*DATA_DEPTH-1:0] r_issue_value;

    // ------------------------------------------------------------------
    // Next-state terms
    // ------------------------------------------------------------------
    logic [BUFFER_NUM-1:0]   w_valid_nxt;
    logic [SPEC_TAG_LEN-1:0] w_mask_nxt [BUFFER_NUM];
    logic [BUFFER_NUM-1:0]   w_wr_en;
    logic [DATA_DEPTH-1:0]   w_wr_data  [BUFFER_NUM];
    logic [BUFFER_SEL:0]     w_free_count_nxt;
    logic [DISP_WIDTH-1:0]   w_alloc_found;
    logic [BUFFER_SEL-1:0]   w_slot_idx;
    logic [SPEC_TAG_LEN-1:0] w_clear_tag;
    logic                    w_disp_en;

    // Free list: the lowest free entries are offered to the dispatch slots.
    // The offer is derived from registered valid bits only, so an entry
    // released this cycle is not offered until the next one.
    imm_value_buffer_free_entry_select #(
        .ENTRY_NUM (BUFFER_NUM),
        .SEL_WIDTH (BUFFER_SEL),
        .PICK_NUM  (DISP_WIDTH)
    ) u_free_sel (
        .free_vec   (~r_valid),
        .pick_ptr   (alloc_ptr),
        .pick_found (w_alloc_found)
    );

    assign alloc_ready = (r_free_count >= (BUFFER_SEL+1)'(DISP_WIDTH));
    assign free_count  = r_free_count;
    assign issue_value = r_issue_value;

    // A misprediction drops the whole dispatch group; a full buffer ignores it.
    assign w_disp_en   = alloc_ready & ~prmiss;

    // A resolved-correct branch no longer constrains anyone, including
    // instructions dispatched in the same cycle.
    assign w_clear_tag = prsuccess ? prtag : '0;

    // Combine issue release, misprediction flush and dispatch writes into
    // the next valid/mask state, and count the resulting free entries.
    always_comb begin
        w_valid_nxt      = r_valid;
        w_wr_en          = '0;
        w_slot_idx       = '0;
        w_free_count_nxt = '0;
        for (int e = 0; e < BUFFER_NUM; e++) begin
            w_mask_nxt[e] = r_mask[e] & ~w_clear_tag;
            w_wr_data[e]  = '0;
        end

        // Entries dependent on the mispredicted branch are squashed
        if (prmiss) begin
            for (int e = 0; e < BUFFER_NUM; e++) begin
                if ((r_mask[e] & prtag) != '0) begin
                    w_valid_nxt[e] = 1'b0;
                end
            end
        end

        // Issued entries are released; issue still applies during a flush
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
            if (issue_valid[j]) begin
                w_valid_nxt[issue_ptr[j*BUFFER_SEL +: BUFFER_SEL]] = 1'b0;
            end
        end

        // Dispatch writes land only in entries that were free, so they never
        // collide with the releases above.
        for (int k = 0; k < DISP_WIDTH; k++) begin
            if (w_disp_en && disp_valid[k] && w_alloc_found[k]) begin
                w_slot_idx              = alloc_ptr[k*BUFFER_SEL +: BUFFER_SEL];
                w_valid_nxt[w_slot_idx] = 1'b1;
                w_wr_en[w_slot_idx]     = 1'b1;
                w_wr_data[w_slot_idx]   = disp_value[k*DATA_DEPTH +: DATA_DEPTH];
                w_mask_nxt[w_slot_idx]  = disp_spectag[k*SPEC_TAG_LEN +: SPEC_TAG_LEN]
                                          & ~w_clear_tag;
            end
        end

        for (int e = 0; e < BUFFER_NUM; e++) begin
            if (!w_valid_nxt[e]) begin
                w_free_count_nxt = w_free_count_nxt + (BUFFER_SEL+1)'(1);
            end
        end
    end

    // Valid bits, dependency masks and the free counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid      <= '0;
            r_free_count <= (BUFFER_SEL+1)'(BUFFER_NUM);
            for (int e = 0; e < BUFFER_NUM; e++) begin
                r_mask[e] <= '0;
            end
        end else begin
            r_valid      <= w_valid_nxt;
            r_free_count <= w_free_count_nxt;
            for (int e = 0; e < BUFFER_NUM; e++) begin
                r_mask[e] <= w_mask_nxt[e];
            end
        end
    end

    // Value storage; contents of free entries are don't-care, so no reset
    always_ff @(posedge clk) begin
        for (int e = 0; e < BUFFER_NUM; e++) begin
            if (w_wr_en[e]) begin
                r_value[e] <= w_wr_data[e];
            end
        end
    end

    // Registered issue read; each port holds its data until its next issue
    always_ff @(posedge clk) begin
        if (reset) begin
            r_issue_value <= '0;
        end else begin
            for (int j = 0; j < ISSUE_WIDTH; j++) begin
                if (issue_valid[j]) begin
                    r_issue_value[j*DATA_DEPTH +: DATA_DEPTH] <=
                        r_value[issue_ptr[j*BUFFER_SEL +: BUFFER_SEL]];
                end
            end
        end
    end

endmodule : imm_value_buffer
`default_nettype wire

// File: tb/tb_imm_value_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imm_value_buffer
//  Description : Self-checking bench for imm_value_buffer. A behavioural model
//                of the entry pool predicts free list, counts and issue data;
//                issue data is checked through an expected-value queue.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_imm_value_buffer;

    localparam int NUM = 32;
    localparam int SEL = 5;
    localparam int DW  = 32;
    localparam int TL  = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic [2*SEL-1:0] alloc_ptr;
    logic            alloc_ready;
    logic [SEL:0]    free_count;
    logic [1:0]      disp_valid;
    logic [2*DW-1:0] disp_value;
    logic [2*TL-1:0] disp_spectag;
    logic [1:0]      issue_valid;
    logic [2*SEL-1:0] issue_ptr;
    logic [2*DW-1:0] issue_value;
    logic            prmiss;
    logic            prsuccess;
    logic [TL-1:0]   prtag;

    always #5 clk = ~clk;

    imm_value_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_ptr    (alloc_ptr),
        .alloc_ready  (alloc_ready),
        .free_count   (free_count),
        .disp_valid   (disp_valid),
        .disp_value   (disp_value),
        .disp_spectag (disp_spectag),
        .issue_valid  (issue_valid),
        .issue_ptr    (issue_ptr),
        .issue_value  (issue_value),
        .prmiss       (prmiss),
        .prsuccess    (prsuccess),
        .prtag        (prtag)
    );

    int tests = 0;
    int fails = 0;

    // Reference model: a pool of entries, each either in use or free
    bit          m_used [NUM];
    logic [31:0] m_data [NUM];
    logic [4:0]  m_tags [NUM];
    logic [31:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_free();
        int n = 0;
        for (int e = 0; e < NUM; e++) if (!m_used[e]) n++;
        return n;
    endfunction

    // Index of the n-th lowest free entry, or -1 when fewer are free
    function automatic int m_nth_free(input int n);
        int seen = 0;
        for (int e = 0; e < NUM; e++) begin
            if (!m_used[e]) begin
                if (seen == n) return e;
                seen++;
            end
        end
        return -1;
    endfunction

    function automatic void m_clear();
        for (int e = 0; e < NUM; e++) begin
            m_used[e] = 1'b0;
            m_tags[e] = '0;
        end
    endfunction

    task automatic check_outputs();
        int fc;
        fc = m_free();
        check("free_count", {26'b0, free_count}, fc);
        check("alloc_ready", {31'b0, alloc_ready}, (fc >= 2) ? 1 : 0);
        for (int k = 0; k < 2; k++) begin
            if (fc >= 2) check("alloc_ptr", {27'b0, alloc_ptr[k*SEL +: SEL]}, m_nth_free(k));
        end
    endtask

    // One clock cycle: check current outputs, drive inputs, advance model
    task automatic step(input logic [1:0] dv, input logic [31:0] v0, input logic [31:0] v1,
                        input logic [4:0] t0, input logic [4:0] t1,
                        input logic [1:0] iv, input logic [4:0] p0, input logic [4:0] p1,
                        input logic pm, input logic ps, input logic [4:0] pt, input logic rst);
        int  a0, a1;
        bit  ready;
        bit  nused [NUM];
        logic [4:0] keep;
        check_outputs();
        reset        = rst;
        disp_valid   = dv;
        disp_value   = {v1, v0};
        disp_spectag = {t1, t0};
        issue_valid  = iv;
        issue_ptr    = {p1, p0};
        prmiss       = pm;
        prsuccess    = ps;
        prtag        = pt;
        if (rst) begin
            m_clear();
        end else begin
            a0    = m_nth_free(0);
            a1    = m_nth_free(1);
            ready = (m_free() >= 2);
            nused = m_used;
            if (iv[0]) begin exp_q.push_back(m_data[p0]); nused[p0] = 1'b0; end
            if (iv[1]) begin exp_q.push_back(m_data[p1]); nused[p1] = 1'b0; end
            if (pm) for (int e = 0; e < NUM; e++) if ((m_tags[e] & pt) != 0) nused[e] = 1'b0;
            keep = ps ? ~pt : 5'h1f;
            for (int e = 0; e < NUM; e++) m_tags[e] = m_tags[e] & keep;
            if (!pm && ready) begin
                if (dv[0]) begin nused[a0] = 1'b1; m_data[a0] = v0; m_tags[a0] = t0 & keep; end
                if (dv[1]) begin nused[a1] = 1'b1; m_data[a1] = v1; m_tags[a1] = t1 & keep; end
            end
            m_used = nused;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    endtask

    // Monitor: one cycle after an issue the port must present the value
    // that was stored in the issued entry
    logic [1:0]  pend_iv  = '0;
    logic        pend_rst = 1'b0;
    logic [31:0] exp_v;
    always @(posedge clk) begin
        pend_iv  <= issue_valid;
        pend_rst <= reset;
    end
    always @(negedge clk) begin
        if (pend_rst) begin
            check("issue_value0_after_reset", issue_value[31:0], 32'h0);
            check("issue_value1_after_reset", issue_value[63:32], 32'h0);
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (pend_iv[j]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL issue_queue: got issue with no expected value");
                    end else begin
                        exp_v = exp_q.pop_front();
                        check("issue_value", issue_value[j*DW +: DW], exp_v);
                    end
                end
            end
        end
    end

    initial begin
        int vlist [$];
        int pick;
        logic [1:0] iv;
        logic [4:0] p0, p1;
        int r;
        logic pm, ps;

        reset = 1'b1; disp_valid = '0; disp_value = '0; disp_spectag = '0;
        issue_valid = '0; issue_ptr = '0; prmiss = 1'b0; prsuccess = 1'b0; prtag = '0;
        m_clear();
        @(posedge clk);
        @(negedge clk);
        step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b1);

        // Two dispatches land in entries 0 and 1
        step(2'b11, 32'hAAAA0000, 32'hBBBB0000, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        check("dir_alloc_ptr0", {27'b0, alloc_ptr[4:0]}, 2);
        check("dir_alloc_ptr1", {27'b0, alloc_ptr[9:5]}, 3);
        check("dir_free_count", {26'b0, free_count}, 30);

        // Issue entry 1; it comes back as the lowest free pointer
        step(2'b00, 0, 0, 0, 0, 2'b01, 5'd1, 0, 1'b0, 1'b0, 0, 1'b0);
        check("dir_reoffer_ptr", {27'b0, alloc_ptr[4:0]}, 1);

        // Fill until one entry remains; further dispatch is ignored
        for (int i = 0; i < 20 && m_free() > 1; i++)
            step(2'b11, $urandom, $urandom, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        check("dir_full_ready", {31'b0, alloc_ready}, 0);
        step(2'b11, 32'h1111, 32'h2222, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        check("dir_full_count", {26'b0, free_count}, 1);

        // Selective recovery: A depends on branch 0, B on branch 1
        step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b1);
        step(2'b11, 32'hA0A0A0A0, 32'hB0B0B0B0, 5'b00001, 5'b00010, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        step(2'b11, 32'hDEAD0001, 32'hDEAD0002, 0, 0, 2'b00, 0, 0, 1'b1, 1'b0, 5'b00010, 1'b0);
        check("dir_prmiss_count", {26'b0, free_count}, 31);
        step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b0, 1'b1, 5'b00001, 1'b0);
        step(2'b00, 0, 0, 0, 0, 2'b00, 0, 0, 1'b1, 1'b0, 5'b00001, 1'b0);
        check("dir_survivor_count", {26'b0, free_count}, 31);
        step(2'b00, 0, 0, 0, 0, 2'b01, 5'd0, 0, 1'b0, 1'b0, 0, 1'b0);

        // Reset while issuing a live entry
        step(2'b11, 32'h5555AAAA, 32'h12345678, 0, 0, 2'b00, 0, 0, 1'b0, 1'b0, 0, 1'b0);
        step(2'b00, 0, 0, 0, 0, 2'b01, 5'd0, 0, 1'b0, 1'b0, 0, 1'b1);
        check("dir_reset_count", {26'b0, free_count}, 32);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            vlist.delete();
            for (int e = 0; e < NUM; e++) if (m_used[e]) vlist.push_back(e);
            iv = '0; p0 = '0; p1 = '0;
            if (vlist.size() > 0 && $urandom_range(0, 99) < 45) begin
                pick = $urandom_range(0, vlist.size() - 1);
                p0 = 5'(vlist[pick]); iv[0] = 1'b1; vlist.delete(pick);
            end
            if (vlist.size() > 0 && $urandom_range(0, 99) < 45) begin
                pick = $urandom_range(0, vlist.size() - 1);
                p1 = 5'(vlist[pick]); iv[1] = 1'b1;
            end
            r  = $urandom_range(0, 99);
            pm = (r < 5);
            ps = (r >= 5 && r < 15);
            step(2'($urandom_range(0, 3)), $urandom, $urandom,
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 iv, p0, p1, pm, ps, 5'(1 << $urandom_range(0, 4)),
                 ($urandom_range(0, 299) == 0));
        end
        idle();
        idle();
        check("exp_queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_imm_value_buffer
`default_nettype wire
